// File: rtl/cache_ctrl.sv
// Blocking controller for a 2-way write-back data cache: tag check, LRU victim write-back, 4-word refill, retry.
// Latency: hit completes 2 cycles after the request is seen; a clean miss takes 2 + 4 fills + 2 cycles.
// Backpressure: CPU is stalled until cpu_ready; memory requests hold address/data steady until mem_ack.
module cache_ctrl #(
  parameter int ADDR_BITS  = 32,
  parameter int TAG_BITS   = 23,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic                 cpu_re,
  input  logic                 cpu_we,
  input  logic [2:0]           cpu_ubhw,
  input  logic [31:0]          cpu_din,
  output logic [31:0]          cpu_dout,
  output logic                 cpu_ready,
  output logic                 cpu_stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_store,
  output logic [2:0]           cache_ubhw,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic [31:0]          cache_dout,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout,
  input  logic                 mem_ack
);

  localparam int WBITS = $clog2(LINE_WORDS);
  localparam int SET_HI = ADDR_BITS - TAG_BITS - 1;
  localparam logic [WBITS-1:0] LAST_WORD = WBITS'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, CHECK, RESULT, WB_RD, WB_WR, FILL} state_t;

  state_t                state;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [2:0]            req_ubhw;
  logic [31:0]           req_din;
  logic                  req_we;
  logic [TAG_BITS-1:0]   victim_tag;
  logic [WBITS-1:0]      wcnt;
  logic [WBITS-1:0]      wcnt_nxt;

  assign wcnt_nxt = wcnt + WBITS'(1);

  // Word address inside the requested line.
  function automatic logic [ADDR_BITS-1:0] line_word(input logic [ADDR_BITS-1:0] a,
                                                     input logic [WBITS-1:0] w);
    return {a[ADDR_BITS-1:WBITS+2], w, 2'b00};
  endfunction

  // Word address inside the victim line (victim tag, same set).
  function automatic logic [ADDR_BITS-1:0] victim_word(input logic [TAG_BITS-1:0] t,
                                                       input logic [ADDR_BITS-1:0] a,
                                                       input logic [WBITS-1:0] w);
    return {t, a[SET_HI:WBITS+2], w, 2'b00};
  endfunction

  // Outputs that depend on same-cycle responses: hit result, fill data path, write-back data.
  assign cpu_ready   = (state == RESULT) && cache_hit;
  assign cpu_dout    = cpu_ready ? cache_dout : '0;
  assign cpu_stall   = (cpu_re | cpu_we) & ~cpu_ready;
  assign cache_store = (state == FILL) && mem_ack;
  assign cache_din   = cache_store ? mem_dout : req_din;
  assign cache_ubhw  = req_ubhw;
  assign mem_din     = (state == WB_WR) ? cache_dout : '0;

  // Sequencer: state, request latches and registered cache/memory strobes for the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_ubhw   <= '0;
      req_din    <= '0;
      req_we     <= 1'b0;
      victim_tag <= '0;
      wcnt       <= '0;
      cache_addr <= '0;
      cache_load <= 1'b0;
      cache_edit <= 1'b0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_re || cpu_we) begin
            req_addr   <= cpu_addr;
            req_ubhw   <= cpu_ubhw;
            req_din    <= cpu_din;
            req_we     <= cpu_we;
            cache_addr <= cpu_addr;
            cache_load <= ~cpu_we;
            cache_edit <= cpu_we;
            state      <= CHECK;
          end
        end
        CHECK: begin
          cache_load <= 1'b0;
          cache_edit <= 1'b0;
          state      <= RESULT;
        end
        RESULT: begin
          if (cache_hit) begin
            state <= IDLE;
          end else begin
            victim_tag <= cache_tag;
            wcnt       <= '0;
            cache_addr <= line_word(req_addr, '0);
            if (cache_valid && cache_dirty) begin
              state <= WB_RD;
            end else begin
              mem_cs   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= line_word(req_addr, '0);
              state    <= FILL;
            end
          end
        end
        WB_RD: begin
          // Cache output of this unstrobed read feeds mem_din during WB_WR.
          mem_cs   <= 1'b1;
          mem_we   <= 1'b1;
          mem_addr <= victim_word(victim_tag, req_addr, wcnt);
          state    <= WB_WR;
        end
        WB_WR: begin
          if (mem_ack) begin
            if (wcnt == LAST_WORD) begin
              wcnt       <= '0;
              mem_we     <= 1'b0;
              mem_addr   <= line_word(req_addr, '0);
              cache_addr <= line_word(req_addr, '0);
              state      <= FILL;
            end else begin
              wcnt       <= wcnt_nxt;
              mem_cs     <= 1'b0;
              mem_we     <= 1'b0;
              cache_addr <= line_word(req_addr, wcnt_nxt);
              state      <= WB_RD;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            wcnt <= wcnt_nxt;
            if (wcnt == LAST_WORD) begin
              // Line complete: replay the original access, which now hits.
              mem_cs     <= 1'b0;
              cache_addr <= req_addr;
              cache_load <= ~req_we;
              cache_edit <= req_we;
              state      <= CHECK;
            end else begin
              mem_addr   <= line_word(req_addr, wcnt_nxt);
              cache_addr <= line_word(req_addr, wcnt_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural 2-way cache and word memory models.
// Latency: memory ack after a programmable number of wait cycles (lat).
// Backpressure: lat > 0 exercises held memory requests.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_ubhw = 3'b010;
  logic [31:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_ready, cpu_stall;
  logic [31:0] cache_addr;
  logic        cache_load, cache_edit, cache_store;
  logic [2:0]  cache_ubhw;
  logic [31:0] cache_din;
  bit          c_hit, c_valid, c_dirty;
  bit   [31:0] c_dout;
  bit   [22:0] c_tag;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout_t;
  logic        mem_ack_t;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_ubhw(cpu_ubhw),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
    .cache_store(cache_store), .cache_ubhw(cache_ubhw), .cache_din(cache_din),
    .cache_hit(c_hit), .cache_dout(c_dout), .cache_valid(c_valid), .cache_dirty(c_dirty),
    .cache_tag(c_tag),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout_t), .mem_ack(mem_ack_t)
  );

  // ---------------- memory model ----------------
  int          lat = 0;
  int          mcnt = 0;
  bit   [31:0] mem [2048];
  bit          mwr [2048];
  logic [10:0] ix;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10C: return 32'h44;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign ix         = mem_addr[12:2];
  assign mem_dout_t = mwr[ix] ? mem[ix] : dflt(mem_addr);
  assign mem_ack_t  = mem_cs && (mcnt == lat);

  always @(posedge clk) begin
    if (mem_cs && !mem_ack_t) mcnt <= mcnt + 1;
    else mcnt <= 0;
    if (mem_cs && mem_we && mem_ack_t) begin
      mem[ix] <= mem_din;
      mwr[ix] <= 1'b1;
    end
  end

  // ---------------- cache model (32 sets x 2 ways x 4 words) ----------------
  bit [22:0] ctag   [2][32];
  bit        cval   [2][32];
  bit        cdirty [2][32];
  bit [31:0] cdata  [2][32][4];
  bit        clru   [32];

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d,
                                      input logic [2:0] ub, input logic [1:0] a);
    bit [31:0] r;
    r = old;
    case (ub[1:0])
      2'b00:   r[8*a +: 8] = d[7:0];
      2'b01:   r[16*a[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : cache_model
    int s, o, w, v;
    bit [22:0] t;
    s = int'(cache_addr[8:4]);
    o = int'(cache_addr[3:2]);
    t = cache_addr[31:9];
    v = int'(clru[s]);
    w = -1;
    if (cval[0][s] && ctag[0][s] == t) w = 0;
    else if (cval[1][s] && ctag[1][s] == t) w = 1;
    c_valid <= cval[v][s];
    c_dirty <= cdirty[v][s];
    c_tag   <= ctag[v][s];
    c_hit   <= 1'b0;
    c_dout  <= cdata[v][s][o];
    if (cache_load) begin
      if (w >= 0) begin
        c_hit   <= 1'b1;
        c_dout  <= cdata[w][s][o];
        clru[s] <= (w == 0);
      end else begin
        c_dout <= '0;
      end
    end else if (cache_edit) begin
      if (w >= 0) begin
        c_hit          <= 1'b1;
        cdata[w][s][o] <= merge(cdata[w][s][o], cache_din, cache_ubhw, cache_addr[1:0]);
        cdirty[w][s]   <= 1'b1;
        clru[s]        <= (w == 0);
      end
    end else if (cache_store) begin
      cdata[v][s][o] <= cache_din;
      ctag[v][s]     <= t;
      cdirty[v][s]   <= 1'b0;
      cval[v][s]     <= (o == 3);
    end
  end

  // ---------------- bookkeeping and checks ----------------
  int          checks = 0, failures = 0;
  int          n_fill = 0, n_wr = 0, n_edit = 0, n_load = 0, n_cs = 0;
  logic [31:0] wr_a[$], wr_d[$], fill_a[$];
  logic        pend = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_din;
  int          r_cyc;
  logic [31:0] r_dout;
  int          b_fill, b_wr, b_edit, b_load, b_cs, b_wq, b_fq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (cache_load || cache_edit || cache_store)
      chk("strobe_onehot", 32'(cache_load) + 32'(cache_edit) + 32'(cache_store), 32'd1);
    if (pend) begin
      chk("hold_addr", mem_addr, p_addr);
      chk("hold_we", 32'(mem_we), 32'(p_we));
      chk("hold_din", mem_din, p_din);
    end
    pend   = mem_cs && !mem_ack_t;
    p_addr = mem_addr;
    p_we   = mem_we;
    p_din  = mem_din;
    if (mem_cs) n_cs++;
    if (cache_load) n_load++;
    if (cache_edit) n_edit++;
    if (cache_store) begin
      n_fill++;
      fill_a.push_back(cache_addr);
    end
    if (mem_cs && mem_we && mem_ack_t) begin
      n_wr++;
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_din);
    end
  endtask

  task automatic snap();
    b_fill = n_fill; b_wr = n_wr; b_edit = n_edit; b_load = n_load; b_cs = n_cs;
    b_wq = wr_a.size(); b_fq = fill_a.size();
  endtask

  task automatic do_req(input string tag, input logic [31:0] a, input logic re, input logic we,
                        input logic [2:0] ub, input logic [31:0] d);
    snap();
    cpu_addr = a; cpu_re = re; cpu_we = we; cpu_ubhw = ub; cpu_din = d;
    r_cyc = 0;
    do begin
      step();
      r_cyc++;
      if (r_cyc == 1) chk({tag, "_stall"}, 32'(cpu_stall), 32'd1);
    end while (!cpu_ready && r_cyc < 300);
    chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    chk({tag, "_stall_rdy"}, 32'(cpu_stall), 32'd0);
    r_dout = cpu_dout;
    cpu_re = 1'b0; cpu_we = 1'b0;
    step();
    chk({tag, "_pulse"}, 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    int k;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_strobes", 32'({cache_load, cache_edit, cache_store, mem_we}), 32'd0);
    chk("rst_cache_addr", cache_addr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dout", cpu_dout, 32'd0);
    rst = 1'b0;
    step();

    // Cold read miss
    do_req("cold", 32'h104, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("cold_lat", 32'(r_cyc), 32'd8);
    chk("cold_dout", r_dout, 32'h22);
    chk("cold_fills", 32'(n_fill - b_fill), 32'd4);
    chk("cold_wr", 32'(n_wr - b_wr), 32'd0);
    chk("cold_fill0", fill_a[b_fq], 32'h100);
    chk("cold_fill3", fill_a[b_fq+3], 32'h10C);

    // Read hit
    do_req("hit", 32'h108, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("hit_lat", 32'(r_cyc), 32'd2);
    chk("hit_dout", r_dout, 32'h33);
    chk("hit_cs", 32'(n_cs - b_cs), 32'd0);

    // Store byte hit
    do_req("sb", 32'h101, 1'b0, 1'b1, 3'b000, 32'hAB);
    chk("sb_lat", 32'(r_cyc), 32'd2);
    chk("sb_edits", 32'(n_edit - b_edit), 32'd1);
    chk("sb_cs", 32'(n_cs - b_cs), 32'd0);

    do_req("lw100", 32'h100, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("lw100_lat", 32'(r_cyc), 32'd2);
    chk("lw100_dout", r_dout, 32'h0000AB11);

    // Both re and we: store wins
    do_req("both", 32'h10C, 1'b1, 1'b1, 3'b010, 32'h77);
    chk("both_lat", 32'(r_cyc), 32'd2);
    chk("both_edits", 32'(n_edit - b_edit), 32'd1);
    chk("both_loads", 32'(n_load - b_load), 32'd0);

    // Make 0x300 line MRU (clean miss into the other way)
    do_req("mru", 32'h304, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("mru_lat", 32'(r_cyc), 32'd8);
    chk("mru_dout", r_dout, 32'hC0DE0304);
    chk("mru_wr", 32'(n_wr - b_wr), 32'd0);

    // Dirty eviction of 0x100 line
    do_req("evict", 32'h504, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("evict_lat", 32'(r_cyc), 32'd16);
    chk("evict_wr", 32'(n_wr - b_wr), 32'd4);
    chk("evict_wa0", wr_a[b_wq], 32'h100);
    chk("evict_wa1", wr_a[b_wq+1], 32'h104);
    chk("evict_wa3", wr_a[b_wq+3], 32'h10C);
    chk("evict_wd0", wr_d[b_wq], 32'h0000AB11);
    chk("evict_wd1", wr_d[b_wq+1], 32'h22);
    chk("evict_wd3", wr_d[b_wq+3], 32'h77);
    chk("evict_fills", 32'(n_fill - b_fill), 32'd4);
    chk("evict_fill0", fill_a[b_fq], 32'h500);
    chk("evict_dout", r_dout, 32'hC0DE0504);
    chk("evict_memword", mem[64], 32'h0000AB11);

    // Dirty the 0x300 line, make it LRU, then evict it under memory backpressure
    do_req("sw300", 32'h300, 1'b0, 1'b1, 3'b010, 32'h5A5A5A5A);
    chk("sw300_lat", 32'(r_cyc), 32'd2);
    do_req("hit504", 32'h504, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("hit504_lat", 32'(r_cyc), 32'd2);
    chk("hit504_dout", r_dout, 32'hC0DE0504);

    lat = 5;
    do_req("bp", 32'h704, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("bp_lat", 32'(r_cyc), 32'd56);
    chk("bp_wr", 32'(n_wr - b_wr), 32'd4);
    chk("bp_wa0", wr_a[b_wq], 32'h300);
    chk("bp_wd0", wr_d[b_wq], 32'h5A5A5A5A);
    chk("bp_fill0", fill_a[b_fq], 32'h700);
    chk("bp_cs_cycles", 32'(n_cs - b_cs), 32'd48);
    chk("bp_dout", r_dout, 32'hC0DE0704);
    lat = 0;

    // Asynchronous reset during the third fill word
    snap();
    cpu_addr = 32'h1004; cpu_re = 1'b1; cpu_we = 1'b0; cpu_ubhw = 3'b010;
    k = 0;
    do begin
      step();
      k++;
    end while (!(cache_store && cache_addr[3:2] == 2'd2) && k < 40);
    chk("rfill_store", 32'(cache_store), 32'd1);
    chk("rfill_addr", mem_addr, 32'h1008);
    rst = 1'b1;
    #1;
    chk("rfill_cs", 32'(mem_cs), 32'd0);
    chk("rfill_ready", 32'(cpu_ready), 32'd0);
    chk("rfill_store0", 32'(cache_store), 32'd0);
    chk("rfill_maddr", mem_addr, 32'd0);
    chk("rfill_caddr", cache_addr, 32'd0);
    cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0;
    step();
    chk("rfill_idle_cs", 32'(mem_cs), 32'd0);

    do_req("reissue", 32'h1004, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("reissue_lat", 32'(r_cyc), 32'd8);
    chk("reissue_fills", 32'(n_fill - b_fill), 32'd4);
    chk("reissue_dout", r_dout, 32'hC0DE1004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
